// File: rtl/range_frame_sequencer.sv
// Sample FIFO feeding the range-finder: replays buffered samples as gap-separated,
// bubble-free sessions of clamp(frame_len, 2, DEPTH) samples with go/finish framing.
module range_frame_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LEN_W = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         sample_in,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  input  logic [LEN_W-1:0]         frame_len,
  output logic [WIDTH-1:0]         data_out,
  output logic                     go,
  output logic                     finish,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wptr, rptr;
  logic [CNT_W-1:0]   rem, rem_n, eff_len;
  logic [WIDTH-1:0]   data_n;
  logic               go_n, finish_n, busy_n;
  logic               push, pop;

  assign sample_ready = (fifo_count != CNT_W'(DEPTH));
  assign push         = sample_valid && sample_ready;

  always_comb begin
    if (32'(frame_len) < 32'd2)
      eff_len = CNT_W'(2);
    else if (32'(frame_len) > DEPTH_W)
      eff_len = CNT_W'(DEPTH);
    else
      eff_len = CNT_W'(frame_len);
  end

  always_comb begin
    state_n  = state;
    rem_n    = rem;
    data_n   = '0;
    go_n     = 1'b0;
    finish_n = 1'b0;
    busy_n   = 1'b0;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        // start decision uses the pre-edge count, so a same-edge push is not counted
        if (fifo_count >= eff_len) begin
          pop     = 1'b1;
          data_n  = mem[rptr];
          go_n    = 1'b1;
          busy_n  = 1'b1;
          rem_n   = eff_len - CNT_W'(1);
          state_n = STREAM;
        end
      end
      STREAM: begin
        pop    = 1'b1;
        data_n = mem[rptr];
        busy_n = 1'b1;
        rem_n  = rem - CNT_W'(1);
        if (rem == CNT_W'(1)) begin
          finish_n = 1'b1;
          state_n  = GAP;
        end
      end
      GAP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= sample_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rem        <= '0;
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      data_out   <= '0;
      go         <= 1'b0;
      finish     <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state    <= state_n;
      rem      <= rem_n;
      data_out <= data_n;
      go       <= go_n;
      finish   <= finish_n;
      busy     <= busy_n;
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (sample_valid && !sample_ready) overflow <= 1'b1;
    end
  end

endmodule
